food_manager: RTL and testbench
===============================

# food_manager

Parametrised successor to the fixed five-apple handler in the snake game. It owns NUM_FOOD food slots on a GRID_W × GRID_H board and places each one pseudo-randomly with an internal LFSR. Placement rejects border cells, enabled wall cells, the snake head and other live food. On a snake step it detects when food is eaten and raises a per-slot pulse that the score and audio blocks consume.

## Interface
- NUM_FOOD, 5, number of food slots (1..16)
- NUM_WALLS, 8, number of wall entries on the wall bus
- GRID_W, 48, board width in cells; playable x is 1..GRID_W-2
- GRID_H, 32, board height in cells; playable y is 1..GRID_H-2
- COORD_W, 6, coordinate width; 2^COORD_W ≥ max(GRID_W, GRID_H)
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- game_status  in  2  00 PAUSED, 01 PLAYING, 10 DIE_FLASHING, 11 INITIALIZING
- step  in  1  one-cycle pulse when the snake has moved
- head_x, head_y  in  COORD_W  snake head cell; valid while step=1
- wall_x_flat, wall_y_flat  in  NUM_WALLS*COORD_W  wall cells; an entry at (0,0) is disabled
- food_x_flat, food_y_flat  out  NUM_FOOD*COORD_W  slot coordinates; slot i occupies bits [i*COORD_W +: COORD_W]
- food_valid  out  NUM_FOOD  slot i is live and must be drawn
- eat  out  NUM_FOOD  one-cycle pulse when slot i is eaten
- busy  out  1  spawn FSM is not IDLE

## Operation
- **LFSR.** 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1. It advances every clock in every game_status and never reaches zero.
- **Candidate cell.** cx = lfsr[COORD_W-1:0], cy = lfsr[8 +: COORD_W].
- **Acceptance.** A candidate is accepted only if all of the following hold:
  - 1 ≤ cx ≤ GRID_W-2 and 1 ≤ cy ≤ GRID_H-2;
  - it matches no enabled wall;
  - it matches no slot with food_valid=1;
  - it is not (head_x, head_y).
- **Spawn FSM states.**
  - IDLE: when spawning is enabled and some slot is invalid, latch the lowest-index invalid slot as the target and go to SEARCH.
  - SEARCH: evaluate the current candidate each cycle. On accept, write the target slot's coordinates, set its valid bit and go to IDLE. On reject, stay in SEARCH; the next cycle brings a new LFSR value. There is no retry cap.
- **Spawn enable.** Spawning is enabled in PLAYING and INITIALIZING. In PAUSED and DIE_FLASHING the FSM holds its state.
- **Eat detection.** Active only when step=1 and game_status=PLAYING. For every slot with food_valid[i]=1 and coordinates equal to the head, register eat[i]=1 and clear food_valid[i]. Live food never overlaps, so at most one bit of eat is set.
- **INITIALIZING entry.** On the first cycle of INITIALIZING (the previous status was not 11), clear all food_valid and force the FSM to IDLE. Slots then refill one by one.
- **Simultaneous eat and spawn.** An eat clears a live slot and a spawn fills an invalid slot, so they never touch the same slot and both take effect. The freed slot becomes eligible at the next IDLE.
- **Reset.** While reset=0, all outputs are 0, the FSM is IDLE and the LFSR holds LFSR_SEED.

## Timing
- eat[i] is high for exactly the cycle after the step cycle. food_valid[i] falls on the same edge.
- Spawn commit:
  - The IDLE → SEARCH decision takes 1 cycle.
  - On accept, food_valid and the coordinates update on the following edge.
  - Minimum refill latency after food_valid falls: 2 cycles.
- busy is registered and is high exactly while the FSM is in SEARCH.
- The acceptance test is fully combinational within SEARCH. The compare fan-in is NUM_WALLS+NUM_FOOD+1 equality checks.
- Reset takes effect asynchronously. Deassertion is synchronous to clock; the first spawn decision happens on the first edge after release.
- Changes to the wall bus take effect on the next candidate evaluation. Food already placed on a newly added wall is not relocated.

## Structure
- Shared package snake_pkg holds:
  - game_status codes PAUSED/PLAYING/DIE_FLASHING/INITIALIZING;
  - the COORD_W default;
  - direction codes UP/RIGHT/DOWN/LEFT.
- Sub-module lfsr16: parameter SEED; ports clock, reset, q[15:0].
- All other logic (slot registers, compare array, FSM) lives in food_manager.

## Test plan
- **Reset fill.** Hold reset=0 for 5 cycles, release, status=11, 200 cycles → food_valid=5'b11111; all coordinates in x 1..46, y 1..30, pairwise distinct, none at (0,0).
- **Eat.** Status=01, drive head to slot 2's coordinates with step=1 → next cycle eat=5'b00100 for one cycle and food_valid[2]=0; food_valid[2]=1 again ≥2 cycles later with new in-range coordinates.
- **Pause.** Status=00, same head-on-food step → eat stays 0, food_valid unchanged, busy frozen.
- **Walls.** Walls at (10,5),(10,21),(40,5),(40,21),(25,9),(25,17),(20,13),(30,13), status=01, 10000 random eat/respawn cycles → no food ever at a wall or the head; eat is always one-hot or zero.
- **Reset mid-search.** Drop reset while busy=1 → all outputs 0 in the same cycle; after release the refill succeeds as in the reset-fill scenario.
- **INITIALIZING mid-game.** Move status 01 → 11 with all slots full → food_valid=0 on the next edge, then all 5 refilled.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: status codes, directions and
// the default coordinate width.
package snake_pkg;

  localparam int COORD_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    PAUSED       = 2'b00,
    PLAYING      = 2'b01,
    DIE_FLASHING = 2'b10,
    INITIALIZING = 2'b11
  } game_status_e;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } direction_e;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// A nonzero seed keeps it out of the all-zero lock-up state forever.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] q
);

  localparam logic [15:0] TAPS = 16'hB400;

  // Shift right every cycle; fold the tap mask back in when a one falls out.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/food_manager.sv
// Owns NUM_FOOD food slots: places each one at a pseudo-random legal cell and
// raises a one-cycle eat pulse when the snake head steps onto live food.
module food_manager
  import snake_pkg::*;
#(
  parameter int          NUM_FOOD  = 5,
  parameter int          NUM_WALLS = 8,
  parameter int          GRID_W    = 48,
  parameter int          GRID_H    = 32,
  parameter int          COORD_W   = COORD_W_DEFAULT,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    game_status,
  input  logic                          step,
  input  logic [COORD_W-1:0]            head_x,
  input  logic [COORD_W-1:0]            head_y,
  input  logic [NUM_WALLS*COORD_W-1:0]  wall_x_flat,
  input  logic [NUM_WALLS*COORD_W-1:0]  wall_y_flat,
  output logic [NUM_FOOD*COORD_W-1:0]   food_x_flat,
  output logic [NUM_FOOD*COORD_W-1:0]   food_y_flat,
  output logic [NUM_FOOD-1:0]           food_valid,
  output logic [NUM_FOOD-1:0]           eat,
  output logic                          busy
);

  typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} spawn_state_e;

  localparam int                 TGT_W = (NUM_FOOD > 1) ? $clog2(NUM_FOOD) : 1;
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 2);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 2);

  game_status_e       status;
  game_status_e       prev_status;
  spawn_state_e       state;
  logic [TGT_W-1:0]   target;
  logic [COORD_W-1:0] slot_x [NUM_FOOD];
  logic [COORD_W-1:0] slot_y [NUM_FOOD];

  logic [15:0]        lfsr;
  logic               unused_lfsr_bits;
  logic [COORD_W-1:0] cx;
  logic [COORD_W-1:0] cy;
  logic               accept;
  logic               has_free;
  logic [TGT_W-1:0]   free_idx;
  logic [NUM_FOOD-1:0] eat_hit;
  logic [NUM_FOOD-1:0] commit_mask;
  logic               spawn_en;
  logic               init_entry;
  logic               commit;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr)
  );

  assign unused_lfsr_bits = ^lfsr;
  assign cx         = lfsr[COORD_W-1:0];
  assign cy         = lfsr[8 +: COORD_W];
  assign status     = game_status_e'(game_status);
  assign spawn_en   = (status == PLAYING) || (status == INITIALIZING);
  assign init_entry = (status == INITIALIZING) && (prev_status != INITIALIZING);
  assign commit     = spawn_en && (state == SEARCH) && accept;

  for (genvar i = 0; i < NUM_FOOD; i++) begin : g_flat
    assign food_x_flat[i*COORD_W +: COORD_W] = slot_x[i];
    assign food_y_flat[i*COORD_W +: COORD_W] = slot_y[i];
  end

  // Acceptance test for the current candidate: playfield, walls, live food, head.
  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    accept = (cx >= ONE) && (cx <= X_MAX) && (cy >= ONE) && (cy <= Y_MAX);
    for (int w = 0; w < NUM_WALLS; w++) begin
      if ((wall_x_flat[w*COORD_W +: COORD_W] != '0 || wall_y_flat[w*COORD_W +: COORD_W] != '0) &&
          wall_x_flat[w*COORD_W +: COORD_W] == cx && wall_y_flat[w*COORD_W +: COORD_W] == cy) begin
        accept = 1'b0;
      end
    end
    for (int i = 0; i < NUM_FOOD; i++) begin
      if (food_valid[i] && slot_x[i] == cx && slot_y[i] == cy) accept = 1'b0;
    end
    if (head_x == cx && head_y == cy) accept = 1'b0;
  end

  // Lowest-index empty slot; scanning downwards lets the lowest index win.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_FOOD - 1; i >= 0; i--) begin
      if (!food_valid[i]) begin
        has_free = 1'b1;
        free_idx = TGT_W'(i);
      end
    end
  end

  // Per-slot eat hits on a playing step, and the one-hot slot a spawn fills.
  always_comb begin
    eat_hit     = '0;
    commit_mask = '0;
    for (int i = 0; i < NUM_FOOD; i++) begin
      eat_hit[i]     = step && (status == PLAYING) && food_valid[i] &&
                       slot_x[i] == head_x && slot_y[i] == head_y;
      commit_mask[i] = commit && (target == TGT_W'(i));
    end
  end

  // Slot registers, eat pulses and the spawn FSM. Coming out of reset counts
  // as already being in INITIALIZING, so the first edge after release makes a
  // spawn decision instead of spending it on a redundant clear.
  // NOTE: the slot coordinate arrays are small register files, so they sit on
  // the async reset like everything else and read back as 0 after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_status <= INITIALIZING;
      state       <= IDLE;
      busy        <= 1'b0;
      target      <= '0;
      food_valid  <= '0;
      eat         <= '0;
      for (int i = 0; i < NUM_FOOD; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
    end else begin
      prev_status <= status;
      eat         <= eat_hit;
      if (init_entry) begin
        food_valid <= '0;
        state      <= IDLE;
        busy       <= 1'b0;
      end else begin
        food_valid <= (food_valid & ~eat_hit) | commit_mask;
        for (int i = 0; i < NUM_FOOD; i++) begin
          if (commit_mask[i]) begin
            slot_x[i] <= cx;
            slot_y[i] <= cy;
          end
        end
        if (spawn_en) begin
          case (state)
            IDLE: begin
              if (has_free) begin
                target <= free_idx;
                state  <= SEARCH;
                busy   <= 1'b1;
              end
            end
            SEARCH: begin
              if (accept) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_food_manager.sv
// Randomized bench for food_manager: a cycle-level reference model built from
// the placement, eat and refill rules, plus scenario checks on the outputs.
module tb_food_manager;

  localparam int NF = 5;
  localparam int NW = 8;
  localparam int GW = 48;
  localparam int GH = 32;
  localparam int CW = 6;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [1:0]         game_status = 2'b11;
  logic               step = 1'b0;
  logic [CW-1:0]      head_x = '0;
  logic [CW-1:0]      head_y = '0;
  logic [NW*CW-1:0]   wall_x_flat = '0;
  logic [NW*CW-1:0]   wall_y_flat = '0;
  logic [NF*CW-1:0]   food_x_flat;
  logic [NF*CW-1:0]   food_y_flat;
  logic [NF-1:0]      food_valid;
  logic [NF-1:0]      eat;
  logic               busy;

  always #5 clock = ~clock;

  food_manager #(
    .NUM_FOOD(NF), .NUM_WALLS(NW), .GRID_W(GW), .GRID_H(GH),
    .COORD_W(CW), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .game_status (game_status),
    .step        (step),
    .head_x      (head_x),
    .head_y      (head_y),
    .wall_x_flat (wall_x_flat),
    .wall_y_flat (wall_y_flat),
    .food_x_flat (food_x_flat),
    .food_y_flat (food_y_flat),
    .food_valid  (food_valid),
    .eat         (eat),
    .busy        (busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [15:0]   m_lfsr;
  logic [NF-1:0] m_valid;
  logic [NF-1:0] m_eat;
  int            m_x [NF];
  int            m_y [NF];
  bit            m_search;
  int            m_target;
  logic [1:0]    m_prev;
  int            wx [NW];
  int            wy [NW];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Galois step built from the polynomial exponents 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int          exps [4] = '{16, 14, 13, 11};
    logic [15:0] mask = '0;
    foreach (exps[k]) mask[exps[k]-1] = 1'b1;
    return (s >> 1) ^ (s[0] ? mask : 16'h0000);
  endfunction

  function automatic bit on_wall(input int x, input int y);
    for (int w = 0; w < NW; w++)
      if ((wx[w] != 0 || wy[w] != 0) && wx[w] == x && wy[w] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit accepts(input int x, input int y);
    if (x < 1 || x > GW - 2 || y < 1 || y > GH - 2) return 1'b0;
    if (on_wall(x, y)) return 1'b0;
    for (int i = 0; i < NF; i++)
      if (m_valid[i] && m_x[i] == x && m_y[i] == y) return 1'b0;
    if (x == int'(head_x) && y == int'(head_y)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_lfsr   = 16'hACE1;
    m_valid  = '0;
    m_eat    = '0;
    m_search = 1'b0;
    m_target = 0;
    m_prev   = 2'b11;
    for (int i = 0; i < NF; i++) begin
      m_x[i] = 0;
      m_y[i] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_edge();
    logic [NF-1:0] eat_n;
    logic [NF-1:0] old_valid;
    int            cx;
    int            cy;
    bit            acc;
    bit            found;
    cx  = int'(m_lfsr[CW-1:0]);
    cy  = int'(m_lfsr[8 +: CW]);
    acc = accepts(cx, cy);
    eat_n = '0;
    if (step && game_status == 2'b01)
      for (int i = 0; i < NF; i++)
        if (m_valid[i] && m_x[i] == int'(head_x) && m_y[i] == int'(head_y)) eat_n[i] = 1'b1;
    old_valid = m_valid;
    if (game_status == 2'b11 && m_prev != 2'b11) begin
      m_valid  = '0;
      m_search = 1'b0;
    end else begin
      m_valid = m_valid & ~eat_n;
      if (game_status == 2'b01 || game_status == 2'b11) begin
        if (m_search) begin
          if (acc) begin
            m_x[m_target]     = cx;
            m_y[m_target]     = cy;
            m_valid[m_target] = 1'b1;
            m_search          = 1'b0;
          end
        end else begin
          found = 1'b0;
          for (int i = 0; i < NF; i++)
            if (!old_valid[i] && !found) begin
              found    = 1'b1;
              m_target = i;
            end
          m_search = found;
        end
      end
    end
    m_eat  = eat_n;
    m_lfsr = lfsr_next(m_lfsr);
    m_prev = game_status;
  endtask

  task automatic compare_all();
    logic [NF*CW-1:0] ex;
    logic [NF*CW-1:0] ey;
    for (int i = 0; i < NF; i++) begin
      ex[i*CW +: CW] = CW'(m_x[i]);
      ey[i*CW +: CW] = CW'(m_y[i]);
    end
    check("food_valid", food_valid, m_valid);
    check("eat", eat, m_eat);
    check("busy", busy, m_search);
    check("food_x", food_x_flat, ex);
    check("food_y", food_y_flat, ey);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, food_valid, '0);
    check({tag, "_eat"}, eat, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_x"}, food_x_flat, '0);
    check({tag, "_y"}, food_y_flat, '0);
  endtask

  task automatic check_fill(input string tag);
    int xi;
    int yi;
    check({tag, "_all_valid"}, food_valid, 5'b11111);
    for (int i = 0; i < NF; i++) begin
      xi = int'(food_x_flat[i*CW +: CW]);
      yi = int'(food_y_flat[i*CW +: CW]);
      check({tag, "_in_range"}, (xi >= 1 && xi <= 46 && yi >= 1 && yi <= 30), 1'b1);
      for (int j = i + 1; j < NF; j++)
        check({tag, "_distinct"}, (food_x_flat[i*CW +: CW] == food_x_flat[j*CW +: CW] &&
                                   food_y_flat[i*CW +: CW] == food_y_flat[j*CW +: CW]), 1'b0);
    end
  endtask

  task automatic fill_until_full(input string tag);
    for (int c = 0; c < 200 && food_valid != 5'b11111; c++) tick();
    check({tag, "_full"}, food_valid, 5'b11111);
  endtask

  task automatic drive_walls();
    for (int w = 0; w < NW; w++) begin
      wall_x_flat[w*CW +: CW] = CW'(wx[w]);
      wall_y_flat[w*CW +: CW] = CW'(wy[w]);
    end
  endtask

  initial begin
    logic [NF-1:0] prev_v;
    logic [NF-1:0] newv;
    int            hx;
    int            hy;
    int            k;
    int            lat;
    bit            refilled;

    for (int w = 0; w < NW; w++) begin
      wx[w] = 0;
      wy[w] = 0;
    end
    drive_walls();
    model_reset();

    // Reset fill.
    repeat (5) begin
      @(posedge clock);
      #1;
      check_outputs_zero("in_reset");
    end
    @(negedge clock);
    reset       = 1'b1;
    game_status = 2'b11;
    repeat (200) tick();
    check_fill("reset_fill");

    // Eat slot 2.
    game_status = 2'b01;
    head_x = CW'(m_x[2]);
    head_y = CW'(m_y[2]);
    step   = 1'b1;
    tick();
    step = 1'b0;
    check("eat_pulse", eat, 5'b00100);
    check("eat_clears", food_valid[2], 1'b0);
    tick();
    check("eat_one_cycle", eat, 5'b00000);
    lat = 1;
    refilled = 1'b0;
    for (int c = 0; c < 100 && !refilled; c++) begin
      tick();
      lat++;
      refilled = food_valid[2];
    end
    check("refill_done", refilled, 1'b1);
    check("refill_latency_ge2", lat >= 2, 1'b1);
    check_fill("after_eat");

    // Pause while searching: eat slot 1, let FSM enter SEARCH, then pause.
    head_x = CW'(m_x[1]);
    head_y = CW'(m_y[1]);
    step   = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check("pause_pre_busy", busy, 1'b1);
    game_status = 2'b00;
    for (int c = 0; c < 3; c++) begin
      head_x = CW'(m_x[0]);
      head_y = CW'(m_y[0]);
      step   = 1'b1;
      tick();
      check("pause_no_eat", eat, 5'b00000);
      check("pause_valid", food_valid, 5'b11101);
      check("pause_busy_frozen", busy, 1'b1);
    end
    step = 1'b0;
    head_x = '0;
    head_y = '0;
    game_status = 2'b01;
    fill_until_full("pause_resume");

    // Walls: re-initialize so every slot is placed with walls present.
    wx = '{10, 10, 40, 40, 25, 25, 20, 30};
    wy = '{ 5, 21,  5, 21,  9, 17, 13, 13};
    drive_walls();
    game_status = 2'b00;
    tick();
    game_status = 2'b11;
    tick();
    check("init_clear_walls", food_valid, 5'b00000);
    fill_until_full("walls_fill");
    for (int i = 0; i < NF; i++)
      check("walls_fill_off_wall",
            on_wall(int'(food_x_flat[i*CW +: CW]), int'(food_y_flat[i*CW +: CW])), 1'b0);
    game_status = 2'b01;
    for (int c = 0; c < 10000; c++) begin
      k = $urandom_range(15);
      game_status = (k == 0) ? 2'b00 : ((k == 1) ? 2'b10 : 2'b01);
      if ($urandom_range(3) == 0) begin
        step = 1'b1;
        if ($urandom_range(1) == 1) begin
          k = $urandom_range(NF - 1);
          head_x = CW'(m_x[k]);
          head_y = CW'(m_y[k]);
        end else begin
          head_x = CW'($urandom_range(63));
          head_y = CW'($urandom_range(63));
        end
      end else begin
        step = 1'b0;
      end
      hx = int'(head_x);
      hy = int'(head_y);
      prev_v = food_valid;
      tick();
      check("eat_onehot0", $onehot0(eat), 1'b1);
      newv = food_valid & ~prev_v;
      for (int i = 0; i < NF; i++) begin
        if (newv[i]) begin
          check("spawn_off_wall",
                on_wall(int'(food_x_flat[i*CW +: CW]), int'(food_y_flat[i*CW +: CW])), 1'b0);
          check("spawn_off_head", (int'(food_x_flat[i*CW +: CW]) == hx &&
                                   int'(food_y_flat[i*CW +: CW]) == hy), 1'b0);
        end
      end
    end
    step = 1'b0;
    game_status = 2'b01;
    fill_until_full("walls_end");

    // Reset mid-search.
    head_x = CW'(m_x[3]);
    head_y = CW'(m_y[3]);
    step   = 1'b1;
    tick();
    step = 1'b0;
    for (int c = 0; c < 10 && !m_search; c++) tick();
    check("midsearch_busy", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    model_reset();
    repeat (3) @(negedge clock);
    check_outputs_zero("held_reset");
    reset       = 1'b1;
    game_status = 2'b11;
    repeat (200) tick();
    check_fill("reset2_fill");

    // INITIALIZING mid-game.
    game_status = 2'b01;
    tick();
    check("pre_init_full", food_valid, 5'b11111);
    game_status = 2'b11;
    tick();
    check("init_clear", food_valid, 5'b00000);
    repeat (200) tick();
    check_fill("init_refill");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
